gf180mcu_fd_sc_mcu9t5v0_drv_seq: RTL and testbench



---
 rtl/gf180mcu_fd_sc_mcu9t5v0_drv_seq_pkg.sv | 7 +
 rtl/gf180mcu_fd_sc_mcu9t5v0_drv_seq_tmr.sv | 20 ++
 rtl/gf180mcu_fd_sc_mcu9t5v0_drv_seq.sv | 87 ++++++++
 tb/tb_gf180mcu_fd_sc_mcu9t5v0_drv_seq.sv | 111 +++++++++++
 4 files changed

// File: rtl/gf180mcu_fd_sc_mcu9t5v0_drv_seq_pkg.sv
// gf180mcu_fd_sc_mcu9t5v0_drv_seq_pkg: shared state encoding and parameter check for the drive sequencer
package gf180mcu_fd_sc_mcu9t5v0_drv_seq_pkg;
   typedef enum logic [1:0] {OFF = 2'b00, UP = 2'b01, ON = 2'b11, DOWN = 2'b10} state_t;
   function automatic bit params_ok(input int nseg, input int step_cyc);
      return nseg >= 2 && step_cyc >= 1;
   endfunction
endpackage

// File: rtl/gf180mcu_fd_sc_mcu9t5v0_drv_seq_tmr.sv
// gf180mcu_fd_sc_mcu9t5v0_drv_seq_tmr: step-interval counter with terminal-count flag
module gf180mcu_fd_sc_mcu9t5v0_drv_seq_tmr
   import gf180mcu_fd_sc_mcu9t5v0_drv_seq_pkg::*;
#(
   parameter int STEP_CYC = 3,
   localparam int CW = $clog2(STEP_CYC + 1)
) (
   input  logic CLK,
   input  logic RN,
   input  logic clr,
   input  logic inc,
   output logic tc
);
   logic [CW-1:0] cnt;
   always_ff @(posedge CLK) begin
      if (!RN || clr) cnt <= '0;
      else if (inc) cnt <= cnt + 1'b1;
   end
   assign tc = cnt == CW'(STEP_CYC - 1);
endmodule

// File: rtl/gf180mcu_fd_sc_mcu9t5v0_drv_seq.sv
// gf180mcu_fd_sc_mcu9t5v0_drv_seq: staggered enable sequencer for a segmented high-drive buffer bank
module gf180mcu_fd_sc_mcu9t5v0_drv_seq
   import gf180mcu_fd_sc_mcu9t5v0_drv_seq_pkg::*;
#(
   parameter int NSEG = 4,
   parameter int STEP_CYC = 3
) (
`ifdef USE_POWER_PINS
   inout  wire             VDD,
   inout  wire             VSS,
`endif
   input  logic            CLK,
   input  logic            RN,
   input  logic            EN,
   output logic [NSEG-1:0] SEG_EN,
   output logic            READY,
   output logic            IDLE,
   output logic            BUSY
);
   if (!params_ok(NSEG, STEP_CYC)) begin : g_bad_params
      $error("drv_seq: NSEG must be >= 2 and STEP_CYC >= 1");
   end
   state_t state, nxt;
   logic [NSEG-1:0] nxt_seg;
   logic clr, inc, tc;
   gf180mcu_fd_sc_mcu9t5v0_drv_seq_tmr #(.STEP_CYC(STEP_CYC)) u_tmr (
      .CLK(CLK), .RN(RN), .clr(clr), .inc(inc), .tc(tc)
   );
   // every direction change restarts the interval, so a dithering EN never steps
   always_comb begin
      nxt = state;
      nxt_seg = SEG_EN;
      clr = 1'b0;
      inc = 1'b0;
      case (state)
         OFF: if (EN) begin
            nxt = UP;
            nxt_seg = {{(NSEG-1){1'b0}}, 1'b1};
            clr = 1'b1;
         end
         UP: if (!EN) begin
            nxt = DOWN;
            clr = 1'b1;
         end else if (tc) begin
            nxt_seg = {SEG_EN[NSEG-2:0], 1'b1};
            nxt = &SEG_EN[NSEG-2:0] ? ON : UP;
            clr = 1'b1;
         end else inc = 1'b1;
         ON: if (!EN) begin
            nxt = DOWN;
            nxt_seg = SEG_EN >> 1;
            clr = 1'b1;
         end
         DOWN: if (EN) begin
            nxt = UP;
            clr = 1'b1;
         end else if (tc) begin
            nxt_seg = SEG_EN >> 1;
            nxt = SEG_EN[1] ? DOWN : OFF;
            clr = 1'b1;
         end else inc = 1'b1;
      endcase
   end
   always_ff @(posedge CLK) begin
      if (!RN) begin
         state <= OFF;
         SEG_EN <= '0;
         READY <= 1'b0;
         IDLE <= 1'b1;
         BUSY <= 1'b0;
      end else begin
         state <= nxt;
         SEG_EN <= nxt_seg;
         READY <= nxt == ON;
         IDLE <= nxt == OFF;
         BUSY <= nxt == UP || nxt == DOWN;
      end
   end
`ifndef FUNCTIONAL
   specify
      (CLK *> SEG_EN) = (1.0, 1.0);
      (CLK => READY) = (1.0, 1.0);
      (CLK => IDLE) = (1.0, 1.0);
      (CLK => BUSY) = (1.0, 1.0);
   endspecify
`endif
endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0_drv_seq.sv
// tb_gf180mcu_fd_sc_mcu9t5v0_drv_seq: scoreboard bench for two sequencer configurations (4x3 and 8x1)
module tb_gf180mcu_fd_sc_mcu9t5v0_drv_seq;
   typedef struct packed {
      logic [7:0] seg;
      logic       ready;
      logic       idle;
      logic       busy;
   } obs_t;
   logic CLK = 1'b0;
   logic RN = 1'b0;
   logic EN = 1'b0;
   logic [3:0] seg_a;
   logic [7:0] seg_b;
   logic ready_a, idle_a, busy_a, ready_b, idle_b, busy_b;
   obs_t qa[$];
   obs_t qb[$];
   int vectors = 0;
   int miscompares = 0;
   int lvl[2] = '{0, 0};
   int age[2] = '{0, 0};
   bit up[2] = '{1'b0, 1'b0};
   always #5 CLK = ~CLK;
   gf180mcu_fd_sc_mcu9t5v0_drv_seq #(.NSEG(4), .STEP_CYC(3)) dut_a (
      .CLK(CLK), .RN(RN), .EN(EN), .SEG_EN(seg_a), .READY(ready_a), .IDLE(idle_a), .BUSY(busy_a)
   );
   gf180mcu_fd_sc_mcu9t5v0_drv_seq #(.NSEG(8), .STEP_CYC(1)) dut_b (
      .CLK(CLK), .RN(RN), .EN(EN), .SEG_EN(seg_b), .READY(ready_b), .IDLE(idle_b), .BUSY(busy_b)
   );
   // reference: count of lit segments, ramp direction and cycles spent waiting at this level
   function automatic obs_t model_step(input int k, input bit en, input bit rn);
      obs_t o;
      int ns = k ? 8 : 4;
      int st = k ? 1 : 3;
      if (!rn) begin
         lvl[k] = 0; age[k] = 0; up[k] = 1'b0;
      end else if (lvl[k] == 0) begin
         if (en) begin lvl[k] = 1; up[k] = 1'b1; age[k] = 0; end
      end else if (lvl[k] == ns) begin
         if (!en) begin lvl[k] = ns - 1; up[k] = 1'b0; age[k] = 0; end
      end else if (en != up[k]) begin
         up[k] = en; age[k] = 0;
      end else if (age[k] == st - 1) begin
         lvl[k] = en ? lvl[k] + 1 : lvl[k] - 1; age[k] = 0;
      end else age[k]++;
      o.seg = 8'((1 << lvl[k]) - 1);
      o.ready = lvl[k] == ns;
      o.idle = lvl[k] == 0;
      o.busy = !o.ready && !o.idle;
      return o;
   endfunction
   task automatic cyc(input bit en, input bit rn);
      @(negedge CLK);
      EN = en;
      RN = rn;
      qa.push_back(model_step(0, en, rn));
      qb.push_back(model_step(1, en, rn));
   endtask
   task automatic chk(input string name, input obs_t act, input obs_t exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s at %0t: got seg=%h r/i/b=%b%b%b, expected seg=%h r/i/b=%b%b%b", name, $time,
                  act.seg, act.ready, act.idle, act.busy, exp.seg, exp.ready, exp.idle, exp.busy);
      end
   endtask
   always @(posedge CLK) begin
      #1;
      if (qa.size() != 0) chk("dut_a_4x3", {4'b0, seg_a, ready_a, idle_a, busy_a}, qa.pop_front());
      if (qb.size() != 0) chk("dut_b_8x1", {seg_b, ready_b, idle_b, busy_b}, qb.pop_front());
      if (RN === 1'b1) begin
         assert ((seg_a & 4'(seg_a + 1'b1)) == 0) else $error("seg_a not thermometer: %b", seg_a);
         assert ((seg_b & 8'(seg_b + 1'b1)) == 0) else $error("seg_b not thermometer: %b", seg_b);
      end
   end
   initial begin
      #500000;
      $display("FAIL watchdog: bench did not complete");
      $fatal(1);
   end
   initial begin
      repeat (2) cyc(1'b0, 1'b0);
      repeat (20) cyc(1'b1, 1'b1);
      repeat (15) cyc(1'b0, 1'b1);
      repeat (4) cyc(1'b1, 1'b1);
      repeat (10) cyc(1'b0, 1'b1);
      repeat (5) cyc(1'b1, 1'b1);
      cyc(1'b1, 1'b0);
      repeat (8) cyc(1'b1, 1'b1);
      repeat (12) begin
         cyc(1'b0, 1'b1);
         cyc(1'b1, 1'b1);
      end
      repeat (15) cyc(1'b0, 1'b1);
      repeat (80) begin
         bit e;
         int n;
         e = 1'(($urandom_range(0, 1)));
         n = $urandom_range(1, 14);
         repeat (n) cyc(e, $urandom_range(0, 39) != 0);
         if ($urandom_range(0, 5) == 0) repeat ($urandom_range(2, 8)) cyc(~e, 1'b1);
      end
      repeat (3) @(negedge CLK);
      vectors++;
      if (qa.size() != 0 || qb.size() != 0) begin
         miscompares++;
         $display("FAIL drain: %0d/%0d entries left, expected 0/0", qa.size(), qb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
